// File: rtl/param_change_monitor.sv
// Multi-channel parameter-change detector: per-field change pulses, settle timer,
// and a held reload request handshake towards the waveform core.
module param_change_monitor #(
    parameter int NUM_CH     = 5,
    parameter int W          = 11,
    parameter int STABLE_CYC = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NUM_CH*W-1:0]   param_bus,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic                  reload_ack,
    output logic [NUM_CH-1:0]     change_pulse,
    output logic                  any_change,
    output logic                  reload_req,
    output logic [NUM_CH-1:0]     changed_ch,
    output logic                  busy
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [NUM_CH-1:0] CH_ZERO = {NUM_CH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REQ    = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic [NUM_CH-1:0]     acc_r, acc_s;
    logic [NUM_CH-1:0]     pend_r, pend_s;
    logic                  req_s;
    logic [NUM_CH-1:0]     changed_s;
    logic [NUM_CH*W-1:0]   shadow_r;
    logic                  prime_r;
    logic [NUM_CH-1:0]     diff_s;
    logic [NUM_CH-1:0]     hit_s;

    // Per-channel compare of the live bus against last cycle's sample
    always_comb begin
        diff_s = CH_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            diff_s[i] = (param_bus[i*W +: W] != shadow_r[i*W +: W]);
        end
    end

    assign hit_s      = change_pulse & ch_mask;
    assign any_change = |hit_s;
    assign busy       = (state_r != ST_IDLE);

    // Shadow sampling and change pulses; the first post-reset edge only primes
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            shadow_r     <= {(NUM_CH*W){1'b0}};
            prime_r      <= 1'b1;
            change_pulse <= CH_ZERO;
        end else if (prime_r) begin
            shadow_r     <= param_bus;
            prime_r      <= 1'b0;
            change_pulse <= CH_ZERO;
        end else begin
            shadow_r     <= param_bus;
            prime_r      <= 1'b0;
            change_pulse <= diff_s;
        end
    end

    // Next-state and next-output logic for the settle/request handshake
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        acc_s     = acc_r;
        pend_s    = pend_r;
        req_s     = reload_req;
        changed_s = changed_ch;
        case (state_r)
            ST_IDLE: begin
                if (|hit_s) begin
                    state_s = ST_SETTLE;
                    cnt_s   = CNT_INIT;
                    acc_s   = hit_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (|hit_s) begin
                    cnt_s = CNT_INIT;
                    acc_s = acc_r | hit_s;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    state_s   = ST_REQ;
                    req_s     = 1'b1;
                    changed_s = acc_r;
                end
            end
            ST_REQ: begin
                // A change seen in the ack cycle folds straight into the next settle
                if (reload_ack) begin
                    req_s     = 1'b0;
                    changed_s = CH_ZERO;
                    pend_s    = CH_ZERO;
                    if (|(pend_r | hit_s)) begin
                        state_s = ST_SETTLE;
                        acc_s   = pend_r | hit_s;
                        cnt_s   = CNT_INIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    pend_s = pend_r | hit_s;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = CNT_ZERO;
                acc_s     = CH_ZERO;
                pend_s    = CH_ZERO;
                req_s     = 1'b0;
                changed_s = CH_ZERO;
            end
        endcase
    end

    // State and handshake registers
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            acc_r      <= CH_ZERO;
            pend_r     <= CH_ZERO;
            reload_req <= 1'b0;
            changed_ch <= CH_ZERO;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            pend_r     <= pend_s;
            reload_req <= req_s;
            changed_ch <= changed_s;
        end
    end

endmodule

// File: tb/tb_param_change_monitor.sv
// Bench for param_change_monitor: directed scenarios plus randomized traffic, two DUTs
// (settle lengths 16 and 1) checked every cycle against a behavioural model.
module tb_param_change_monitor;

    localparam int N  = 5;
    localparam int W  = 11;
    localparam int BW = N * W;

    typedef struct packed {
        logic          prime;
        logic [BW-1:0] shadow;
        logic [N-1:0]  pulse;
        logic [1:0]    phase;   // 0 idle, 1 settling, 2 requesting
        logic [31:0]   quiet;   // consecutive change-free edges while settling
        logic [N-1:0]  acc;
        logic [N-1:0]  pend;
        logic          req;
        logic [N-1:0]  cc;
    } mdl_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] bus;
    logic [N-1:0]  mask;
    logic          ack;
    logic [N-1:0]  pulse_a, cc_a, pulse_b, cc_b;
    logic          any_a, req_a, busy_a, any_b, req_b, busy_b;
    mdl_t          ma, mb;
    logic          chk_en = 1'b0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    param_change_monitor #(.NUM_CH(N), .W(W), .STABLE_CYC(16)) u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .param_bus(bus), .ch_mask(mask),
        .reload_ack(ack), .change_pulse(pulse_a), .any_change(any_a),
        .reload_req(req_a), .changed_ch(cc_a), .busy(busy_a));

    param_change_monitor #(.NUM_CH(N), .W(W), .STABLE_CYC(1)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .param_bus(bus), .ch_mask(mask),
        .reload_ack(ack), .change_pulse(pulse_b), .any_change(any_b),
        .reload_req(req_b), .changed_ch(cc_b), .busy(busy_b));

    // Reference: one clock edge of the monitor, from the behavioural rules
    function automatic mdl_t mstep(mdl_t s, logic rn, logic [BW-1:0] b,
                                   logic [N-1:0] mk, logic ak, int stab);
        mdl_t n;
        logic [N-1:0] m;
        logic [N-1:0] coll;
        n = s;
        if (!rn) begin
            n = '0;
            n.prime = 1'b1;
            return n;
        end
        m = s.pulse & mk;
        for (int c = 0; c < N; c++)
            n.pulse[c] = s.prime ? 1'b0 : (b[c*W +: W] != s.shadow[c*W +: W]);
        n.shadow = b;
        n.prime  = 1'b0;
        if (s.phase == 2'd0) begin
            if (m != 0) begin
                n.phase = 2'd1; n.quiet = 0; n.acc = m;
            end
        end else if (s.phase == 2'd1) begin
            if (m != 0) begin
                n.quiet = 0; n.acc = s.acc | m;
            end else begin
                n.quiet = s.quiet + 1;
                if (n.quiet == 32'(stab)) begin
                    n.phase = 2'd2; n.req = 1'b1; n.cc = s.acc;
                end
            end
        end else begin
            if (ak) begin
                coll = s.pend | m;
                n.req = 1'b0; n.cc = '0; n.pend = '0;
                if (coll != 0) begin
                    n.phase = 2'd1; n.acc = coll; n.quiet = 0;
                end else begin
                    n.phase = 2'd0;
                end
            end else begin
                n.pend = s.pend | m;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, rst_n, bus, mask, ack, 16);
        mb <= mstep(mb, rst_n, bus, mask, ack, 1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_pulse", 32'(pulse_a), 32'(ma.pulse));
            check("a_any",   32'(any_a),   32'(|(ma.pulse & mask)));
            check("a_req",   32'(req_a),   32'(ma.req));
            check("a_cc",    32'(cc_a),    32'(ma.cc));
            check("a_busy",  32'(busy_a),  32'(ma.phase != 2'd0));
            check("b_pulse", 32'(pulse_b), 32'(mb.pulse));
            check("b_any",   32'(any_b),   32'(|(mb.pulse & mask)));
            check("b_req",   32'(req_b),   32'(mb.req));
            check("b_cc",    32'(cc_b),    32'(mb.cc));
            check("b_busy",  32'(busy_b),  32'(mb.phase != 2'd0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        bus[c*W +: W] = v;
    endtask

    task automatic wait_req(inout int d);
        int lim;
        lim = d + 80;
        while (req_a !== 1'b1 && d < lim) begin
            tick();
            d++;
        end
        if (req_a !== 1'b1) check("req_timeout", 32'(req_a), 32'd1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int d;
        logic seen;
        rst_n = 1'b0;
        mask  = 5'b11111;
        ack   = 1'b0;
        bus   = '0;
        set_ch(0, 11'd5);
        set_ch(1, 11'd3);
        set_ch(2, 11'd300);
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_pulse", 32'(pulse_a), 32'd0);
        check("rst_req",   32'(req_a),   32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);

        // Priming: power-up values never raise anything
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pulse_a != 0 || req_a || busy_a) seen = 1'b1;
        end
        check("prime_quiet", 32'(seen), 32'd0);

        // Single change on ch1
        set_ch(1, 11'd4);
        tick(); d = 0;
        check("single_pulse", 32'(pulse_a), 32'h02);
        tick(); d = 1;
        check("single_pulse_end", 32'(pulse_a), 32'h00);
        check("single_busy", 32'(busy_a), 32'd1);
        check("s1_busy", 32'(busy_b), 32'd1);
        check("s1_noreq", 32'(req_b), 32'd0);
        tick(); d = 2;
        check("s1_req", 32'(req_b), 32'd1);
        check("s1_cc", 32'(cc_b), 32'h02);
        wait_req(d);
        check("single_lat", 32'(d), 32'd17);
        check("single_cc", 32'(cc_a), 32'h02);
        tick(); tick(); tick();
        check("single_hold", 32'(req_a), 32'd1);
        do_ack();
        check("single_ack_req", 32'(req_a), 32'd0);
        check("single_ack_idle", 32'(busy_a), 32'd0);

        // Burst: ch0 then ch3 ten edges later restarts the settle window
        set_ch(0, 11'd6);
        tick(); d = 0;
        for (int i = 0; i < 9; i++) begin tick(); d++; end
        set_ch(3, 11'd77);
        tick(); d++;
        wait_req(d);
        check("burst_lat", 32'(d), 32'd27);
        check("burst_cc", 32'(cc_a), 32'h09);
        do_ack();

        // Change while requesting is held pending until the ack
        set_ch(2, 11'd301);
        tick(); d = 0;
        wait_req(d);
        check("req_lat", 32'(d), 32'd17);
        set_ch(4, 11'd7);
        tick(); tick(); tick();
        check("req_frozen_cc", 32'(cc_a), 32'h04);
        check("req_held", 32'(req_a), 32'd1);
        do_ack(); d = 0;
        check("pend_settle", 32'(busy_a), 32'd1);
        check("pend_req_low", 32'(req_a), 32'd0);
        check("pend_cc_low", 32'(cc_a), 32'd0);
        wait_req(d);
        check("pend_lat", 32'(d), 32'd16);
        check("pend_cc", 32'(cc_a), 32'h10);
        do_ack();
        check("pend_idle", 32'(busy_a), 32'd0);

        // Change pulse present in the very cycle the ack arrives
        set_ch(1, 11'd9);
        tick(); d = 0;
        wait_req(d);
        set_ch(2, 11'd5);
        tick();
        do_ack(); d = 0;
        check("ackcyc_settle", 32'(busy_a), 32'd1);
        check("ackcyc_req_low", 32'(req_a), 32'd0);
        wait_req(d);
        check("ackcyc_lat", 32'(d), 32'd16);
        check("ackcyc_cc", 32'(cc_a), 32'h04);
        do_ack();

        // Masked channel: pulses only, glitch gives two pulses
        mask = 5'b11110;
        set_ch(0, 11'd7);
        tick();
        check("mask_pulse", 32'(pulse_a), 32'h01);
        check("mask_any", 32'(any_a), 32'd0);
        set_ch(0, 11'd6);
        tick();
        check("mask_pulse2", 32'(pulse_a), 32'h01);
        tick();
        check("mask_idle", 32'(busy_a), 32'd0);

        // Reset in the middle of settling
        mask = 5'b11111;
        set_ch(3, 11'd78);
        tick(); tick();
        check("mid_settle", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mrst_pulse", 32'(pulse_a), 32'd0);
        check("mrst_req",   32'(req_a),   32'd0);
        check("mrst_busy",  32'(busy_a),  32'd0);
        check("mrst_cc",    32'(cc_a),    32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (req_a || busy_a) seen = 1'b1;
        end
        check("mrst_no_req", 32'(seen), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 47) == 0)
                set_ch(int'($urandom_range(0, N - 1)), W'($urandom));
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) mask = N'($urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
